// File: rtl/sao_pkg.sv
// Shared SAO definitions: frame geometry, feeder state encoding
// and LCU size decode helpers.
package sao_pkg;

    localparam int FRM_W  = 128;
    localparam int FRM_H  = 64;
    localparam int PRM_W  = 24;
    localparam int FRM_AW = 14;
    localparam int PRM_AW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_LOAD,
        S_WAIT_RDY,
        S_BURST,
        S_WAIT_ACK,
        S_DONE
    } feed_state_t;

    function automatic logic [2:0] log2n(input logic [1:0] sz);
        return 3'd4 + {1'b0, sz};
    endfunction

    function automatic logic [5:0] n_mask(input logic [1:0] sz);
        logic [6:0] n;
        n = 7'd16 << sz;
        return 6'(n - 7'd1);
    endfunction

    function automatic logic [2:0] grid_xmax(input logic [1:0] sz);
        logic [7:0] w;
        w = 8'(FRM_W) >> log2n(sz);
        return 3'(w - 8'd1);
    endfunction

    function automatic logic [2:0] grid_ymax(input logic [1:0] sz);
        logic [7:0] h;
        h = 8'(FRM_H) >> log2n(sz);
        return 3'(h - 8'd1);
    endfunction

endpackage

// File: rtl/lcu_addr_gen.sv
// Pixel and LCU counters for the feeder; produces frame/parameter
// SRAM addresses using shifts only, plus last-pixel/last-LCU flags.
module lcu_addr_gen
    import sao_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_pix_adv,
    input  logic              i_lcu_adv,
    input  logic [1:0]        i_size,
    output logic [FRM_AW-1:0] o_frm_addr,
    output logic [PRM_AW-1:0] o_prm_addr,
    output logic [2:0]        o_lcu_x,
    output logic [2:0]        o_lcu_y,
    output logic              o_last_pix,
    output logic              o_last_lcu
);

    logic [5:0] r_px;
    logic [5:0] r_py;
    logic [2:0] r_lcu_x;
    logic [2:0] r_lcu_y;

    logic [2:0] w_l2n;
    logic [5:0] w_mask;
    logic [2:0] w_xmax;
    logic [2:0] w_ymax;
    logic       w_px_end;
    logic       w_py_end;
    logic       w_x_end;
    logic [5:0] w_row;
    logic [6:0] w_col;

    assign w_l2n    = log2n(i_size);
    assign w_mask   = n_mask(i_size);
    assign w_xmax   = grid_xmax(i_size);
    assign w_ymax   = grid_ymax(i_size);
    assign w_px_end = (r_px == w_mask);
    assign w_py_end = (r_py == w_mask);
    assign w_x_end  = (r_lcu_x == w_xmax);

    // px/py never exceed N-1, so OR-ing them onto the LCU origin is an add
    assign w_row = ({3'b0, r_lcu_y} << w_l2n) | r_py;
    assign w_col = ({4'b0, r_lcu_x} << w_l2n) | {1'b0, r_px};

    assign o_frm_addr = {1'b0, w_row, w_col};
    assign o_prm_addr = ({3'b0, r_lcu_y} << (3'd7 - w_l2n))
                      | {3'b0, r_lcu_x};
    assign o_lcu_x    = r_lcu_x;
    assign o_lcu_y    = r_lcu_y;
    assign o_last_pix = w_px_end && w_py_end;
    assign o_last_lcu = w_x_end && (r_lcu_y == w_ymax);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_px    <= 6'd0;
            r_py    <= 6'd0;
            r_lcu_x <= 3'd0;
            r_lcu_y <= 3'd0;
        end else if (i_start) begin
            r_px    <= 6'd0;
            r_py    <= 6'd0;
            r_lcu_x <= 3'd0;
            r_lcu_y <= 3'd0;
        end else begin
            if (i_pix_adv) begin
                r_px <= w_px_end ? 6'd0 : r_px + 6'd1;
                if (w_px_end) begin
                    r_py <= w_py_end ? 6'd0 : r_py + 6'd1;
                end
            end
            if (i_lcu_adv) begin
                r_lcu_x <= w_x_end ? 3'd0 : r_lcu_x + 3'd1;
                if (w_x_end) begin
                    r_lcu_y <= r_lcu_y + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sao_lcu_feeder.sv
// SAO upstream feeder: fetches per-LCU parameters and pixels from
// SRAM and streams LCUs in raster order under the SAO busy handshake.
module sao_lcu_feeder
    import sao_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic [FRM_AW-1:0] frm_addr,
    output logic              frm_cen,
    input  logic [7:0]        frm_q,
    output logic [PRM_AW-1:0] prm_addr,
    output logic              prm_cen,
    input  logic [PRM_W-1:0]  prm_q,
    input  logic              busy,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        sao_type,
    output logic [4:0]        sao_band_pos,
    output logic              sao_eo_class,
    output logic [15:0]       sao_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    feed_state_t      r_state;
    logic             r_frm_cen;
    logic             r_prm_cen;
    logic             r_in_en;
    logic             r_done;
    logic [1:0]       r_lcu_size;
    logic [PRM_W-1:0] r_prm_stage;
    logic [PRM_W-1:0] r_prm;

    logic w_go;
    logic w_pix_adv;
    logic w_lcu_adv;
    logic w_last_pix;
    logic w_last_lcu;

    assign w_go      = (r_state == S_IDLE) && start
                     && (cfg_lcu_size != 2'd3);
    assign w_pix_adv = (r_state == S_BURST);
    assign w_lcu_adv = (r_state == S_WAIT_ACK) && busy && !w_last_lcu;

    lcu_addr_gen u_addr (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (w_go),
        .i_pix_adv  (w_pix_adv),
        .i_lcu_adv  (w_lcu_adv),
        .i_size     (r_lcu_size),
        .o_frm_addr (frm_addr),
        .o_prm_addr (prm_addr),
        .o_lcu_x    (lcu_x),
        .o_lcu_y    (lcu_y),
        .o_last_pix (w_last_pix),
        .o_last_lcu (w_last_lcu)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frm_cen   <= 1'b1;
            r_prm_cen   <= 1'b1;
            r_in_en     <= 1'b0;
            r_done      <= 1'b0;
            r_lcu_size  <= 2'd0;
            r_prm_stage <= '0;
            r_prm       <= '0;
        end else begin
            r_in_en <= (r_state == S_BURST);
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_lcu_size <= cfg_lcu_size;
                        r_prm_cen  <= 1'b0;
                        r_state    <= S_PARAM;
                    end
                end
                S_PARAM: begin
                    r_prm_cen <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    r_prm_stage <= prm_q;
                    r_state     <= S_WAIT_RDY;
                end
                // staged params go live only once SAO has left CAL
                S_WAIT_RDY: begin
                    if (!busy) begin
                        r_prm     <= r_prm_stage;
                        r_frm_cen <= 1'b0;
                        r_state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_last_pix) begin
                        r_frm_cen <= 1'b1;
                        r_state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (busy) begin
                        if (w_last_lcu) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_prm_cen <= 1'b0;
                            r_state   <= S_PARAM;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frm_cen      = r_frm_cen;
    assign prm_cen      = r_prm_cen;
    assign in_en        = r_in_en;
    assign din          = r_in_en ? frm_q : 8'd0;
    assign sao_type     = r_prm[23:22];
    assign sao_band_pos = r_prm[21:17];
    assign sao_eo_class = r_prm[16];
    assign sao_offset   = r_prm[15:0];
    assign lcu_size     = r_lcu_size;
    assign done         = r_done;

endmodule
